// File: rtl/match_scoreboard.sv
// Tug-of-war match scoreboard: round-win detection, per-side scores,
// active-low score digits, timed autoReset pulse and match-over latch.
module match_scoreboard #(
  parameter int unsigned WIN_SCORE   = 7,
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned HOLD_W      = 8
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       L,
  input  logic       R,
  input  logic       LED9,
  input  logic       LED1,
  output logic [6:0] HEX1,
  output logic [6:0] HEX0,
  output logic       autoReset,
  output logic       match_over,
  output logic       left_won,
  output logic       right_won
);

  typedef enum logic [1:0] {
    PLAY,
    HOLD,
    RESTART,
    DONE
  } state_t;

  localparam logic [2:0] WIN =
    3'(WIN_SCORE);
  localparam logic [HOLD_W-1:0] HOLD_LAST =
    HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [6:0] SEG_ZERO = 7'b1000000;

  state_t            state_q;
  logic [2:0]        lscore_q;
  logic [2:0]        rscore_q;
  logic [2:0]        lscore_d;
  logic [2:0]        rscore_d;
  logic [HOLD_W-1:0] cnt_q;
  logic              accept;
  logic              lwin;
  logic              rwin;

  function automatic logic [6:0] seg7(
    input logic [2:0] v
  );
    logic [6:0] s;
    unique case (v)
      3'd0: s = 7'b1000000;
      3'd1: s = 7'b1111001;
      3'd2: s = 7'b0100100;
      3'd3: s = 7'b0110000;
      3'd4: s = 7'b0011001;
      3'd5: s = 7'b0010010;
      3'd6: s = 7'b0000010;
      3'd7: s = 7'b1111000;
    endcase
    return s;
  endfunction

  function automatic logic [2:0] sat_inc(
    input logic [2:0] v
  );
    return (v == 3'd7) ? v : v + 3'd1;
  endfunction

  // The pulse cycle itself is still old-round time: the light chain
  // only recentres on the following edge, so wins are gated here.
  assign accept = (state_q == PLAY) && !autoReset;
  assign lwin   = accept & LED9 & L & ~(LED1 & R);
  assign rwin   = accept & LED1 & R & ~(LED9 & L);

  assign lscore_d = lwin ? sat_inc(lscore_q) : lscore_q;
  assign rscore_d = rwin ? sat_inc(rscore_q) : rscore_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= PLAY;
      lscore_q   <= '0;
      rscore_q   <= '0;
      cnt_q      <= '0;
      HEX1       <= SEG_ZERO;
      HEX0       <= SEG_ZERO;
      autoReset  <= 1'b0;
      match_over <= 1'b0;
      left_won   <= 1'b0;
      right_won  <= 1'b0;
    end else begin
      autoReset <= 1'b0;
      unique case (state_q)
        PLAY: begin
          if (lwin || rwin) begin
            lscore_q <= lscore_d;
            rscore_q <= rscore_d;
            HEX1     <= seg7(lscore_d);
            HEX0     <= seg7(rscore_d);
            cnt_q    <= '0;
            if (lwin && lscore_d == WIN) begin
              state_q    <= DONE;
              match_over <= 1'b1;
              left_won   <= 1'b1;
            end else if (rwin && rscore_d == WIN) begin
              state_q    <= DONE;
              match_over <= 1'b1;
              right_won  <= 1'b1;
            end else begin
              state_q <= HOLD;
            end
          end
        end
        HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            state_q <= RESTART;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        RESTART: begin
          autoReset <= 1'b1;
          state_q   <= PLAY;
        end
        DONE: begin
          state_q <= DONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_match_scoreboard.sv
// Scoreboard bench for match_scoreboard: a timeline model of the
// game pushes expected outputs, a monitor compares every cycle.
module tb_match_scoreboard;

  localparam int WS = 7;
  localparam int HC = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       L = 1'b0;
  logic       R = 1'b0;
  logic       LED9 = 1'b0;
  logic       LED1 = 1'b0;
  logic [6:0] HEX1;
  logic [6:0] HEX0;
  logic       autoReset;
  logic       match_over;
  logic       left_won;
  logic       right_won;

  match_scoreboard #(
    .WIN_SCORE  (WS),
    .HOLD_CYCLES(HC),
    .HOLD_W     (8)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .L         (L),
    .R         (R),
    .LED9      (LED9),
    .LED1      (LED1),
    .HEX1      (HEX1),
    .HEX0      (HEX0),
    .autoReset (autoReset),
    .match_over(match_over),
    .left_won  (left_won),
    .right_won (right_won)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] h1;
    logic [6:0] h0;
    logic       ar;
    logic       mo;
    logic       lw;
    logic       rw;
  } obs_t;

  obs_t q[$];
  int errors = 0;
  int checks = 0;

  // Timeline model: edge index k, scores, and the edges at which
  // the pulse fires and new wins are accepted again.
  int k = 0;
  int ls, rs;
  int ar_edge, accept_edge;
  bit done, lwon, rwon;

  function automatic logic [6:0] seg(input int v);
    logic [6:0] t [8];
    t = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
          7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000};
    return t[v];
  endfunction

  function automatic obs_t cur();
    return '{HEX1, HEX0, autoReset, match_over, left_won, right_won};
  endfunction

  function automatic obs_t model_out();
    return '{seg(ls), seg(rs), (k == ar_edge), done, lwon, rwon};
  endfunction

  task automatic model_reset();
    ls = 0; rs = 0;
    done = 0; lwon = 0; rwon = 0;
    ar_edge = -1000;
    accept_edge = 0;
  endtask

  task automatic model_edge(input bit l, r, l9, l1);
    bit lw, rw;
    k++;
    if (done || k < accept_edge) return;
    lw = l9 && l && !(l1 && r);
    rw = l1 && r && !(l9 && l);
    if (lw) ls = (ls < 7) ? ls + 1 : 7;
    if (rw) rs = (rs < 7) ? rs + 1 : 7;
    if ((lw && ls == WS) || (rw && rs == WS)) begin
      done = 1;
      lwon = lw;
      rwon = rw;
    end else if (lw || rw) begin
      ar_edge = k + HC + 1;
      accept_edge = k + HC + 3;
    end
  endtask

  task automatic check(input string nm, input obs_t act, input obs_t exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s t=%0t got h1=%b h0=%b ar=%b mo=%b lw=%b rw=%b want h1=%b h0=%b ar=%b mo=%b lw=%b rw=%b",
               nm, $time, act.h1, act.h0, act.ar, act.mo, act.lw, act.rw,
               exp.h1, exp.h0, exp.ar, exp.mo, exp.lw, exp.rw);
    end
  endtask

  task automatic step(input bit l, r, l9, l1);
    @(negedge clk);
    #1;
    L = l; R = r; LED9 = l9; LED1 = l1;
    if (reset) model_edge(l, r, l9, l1);
    q.push_back(model_out());
  endtask

  // Reset is asserted mid-cycle and checked before any clock edge.
  task automatic reset_pulse(input int cycles);
    @(negedge clk);
    #1;
    reset = 1'b0;
    L = 0; R = 0; LED9 = 0; LED1 = 0;
    model_reset();
    #1;
    check("async_reset", cur(), model_out());
    q.push_back(model_out());
    repeat (cycles - 1) begin
      @(negedge clk);
      #1;
      q.push_back(model_out());
    end
    @(negedge clk);
    #1;
    reset = 1'b1;
    model_edge(0, 0, 0, 0);
    q.push_back(model_out());
  endtask

  initial begin : monitor
    obs_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        check("cycle", cur(), e);
      end
    end
  end

  initial begin : stim
    model_reset();
    reset_pulse(2);
    repeat (10) step(0, 0, 0, 0);

    step(0, 1, 0, 1);
    repeat (8) step(0, 0, 0, 1);

    step(0, 1, 0, 1);
    repeat (3) begin
      step(0, 1, 0, 1);
      step(0, 0, 0, 1);
    end
    repeat (6) step(0, 0, 0, 0);

    step(1, 1, 1, 1);
    repeat (7) step(0, 0, 0, 0);

    reset_pulse(1);
    repeat (7) begin
      step(1, 0, 1, 0);
      repeat (7) step(0, 0, 1, 0);
    end
    repeat (4) step(1, 1, 1, 1);
    repeat (4) step(0, 1, 0, 1);
    repeat (4) step(1, 0, 1, 0);

    reset_pulse(2);
    step(0, 1, 0, 1);
    step(0, 0, 0, 0);
    step(0, 0, 0, 0);
    reset_pulse(2);
    repeat (10) step(0, 0, 0, 0);

    for (int i = 0; i < 600; i++) begin
      if (i % 150 == 149) reset_pulse($urandom_range(1, 3));
      step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
           $urandom_range(0, 1) == 1, $urandom_range(0, 1) == 1);
    end

    repeat (3) @(negedge clk);
    #2;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain left=%0d want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
